act_sequencer: RTL

ACT_SEQUENCER -- requirements
Module: act_sequencer

---
 rtl/act_sequencer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/act_sequencer.sv
// rtl/act_sequencer.sv - tile row sequencer: stage register, external activation unit, output FIFO; define ACT_SEQ_PERF_EN for stall_cycles
module act_sequencer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  cfg_mode,
    input  logic        cfg_float,
    input  logic [7:0]  cfg_rows,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    output logic [63:0] act_in,
    output logic [2:0]  act_mode,
    output logic        act_float,
    input  logic [63:0] act_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        busy,
    output logic        done,
    output logic        err
`ifdef ACT_SEQ_PERF_EN
    ,
    output logic [15:0] stall_cycles
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [7:0]        rows_left;
    logic [2:0]        mode_q;
    logic              float_q;
    logic              stage_valid;
    logic [63:0]       stage_data;
    logic [63:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  occupancy;
    logic              start_ok;
    logic              busy_st;
    logic              done_st;
    logic              err_st;
    logic              accept;
    logic              push;
    logic              pop;

    // Rows in flight: FIFO entries plus the one sitting in the stage register.
    assign occupancy = fifo_count + CNT_W'(stage_valid);

    // Outputs are forced quiet while rst is high so nothing leaks during reset.
    assign in_ready  = !rst && (state == S_RUN) && (rows_left != 8'd0) && (occupancy < DEPTH_C);
    assign accept    = in_valid && in_ready;
    assign push      = stage_valid;
    assign out_valid = !rst && (fifo_count != '0);
    assign pop       = out_valid && out_ready;
    assign out_data  = mem[rd_ptr];
    assign act_in    = rst ? 64'd0 : stage_data;
    assign act_mode  = mode_q;
    assign act_float = float_q;
    assign busy      = !rst && busy_st;
    assign done      = !rst && done_st;
    assign err       = !rst && err_st;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and status decode; start is only looked at in IDLE.
    always_comb begin
        state_next = state;
        start_ok   = 1'b0;
        busy_st    = 1'b0;
        done_st    = 1'b0;
        err_st     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (cfg_mode <= 3'd3) begin
                        start_ok   = 1'b1;
                        state_next = (cfg_rows == 8'd0) ? S_DONE : S_RUN;
                    end else begin
                        err_st = 1'b1;
                    end
                end
            end
            S_RUN: begin
                busy_st = 1'b1;
                if (rows_left == 8'd0) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy_st = 1'b1;
                if (!stage_valid && (fifo_count == '0)) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                done_st    = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Tile configuration latch, row countdown, stage register and FIFO bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            rows_left   <= 8'd0;
            mode_q      <= 3'd0;
            float_q     <= 1'b0;
            stage_valid <= 1'b0;
            stage_data  <= 64'd0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
        end else begin
            if (start_ok) begin
                mode_q    <= cfg_mode;
                float_q   <= cfg_float;
                rows_left <= cfg_rows;
            end else if (accept) begin
                rows_left <= rows_left - 8'd1;
            end
            stage_valid <= accept;
            if (accept) begin
                stage_data <= in_data;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // FIFO storage; a valid stage always has room because in_ready reserved it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= act_out;
        end
    end

`ifdef ACT_SEQ_PERF_EN
    // Count backpressure cycles during a tile, saturating.
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            stall_cycles <= 16'd0;
        end else if (busy && out_valid && !out_ready && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end
`endif

endmodule
